logic_unit_arbiter: RTL and testbench

//  Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR; XOR is the xor32 path) among NUM_REQ requesters.

---
 rtl/logic_unit_arbiter.sv | 135 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit (AND/OR/XOR/NOR) among NUM_REQ requesters.
// Optional macro LU_ARB_STATS_EN adds a 32-bit completed-operation counter output (op_count).
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [2*NUM_REQ-1:0]    req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic [IDW-1:0]          resp_id,
  output logic                    busy
`ifdef LU_ARB_STATS_EN
  ,
  output logic [31:0]             op_count
`endif
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      winner;
  logic                found;
  logic [DATA_W-1:0]   a_p0, b_p0;
  logic [1:0]          op_p0;
  logic [IDW-1:0]      id_p0;

  function automatic logic [DATA_W-1:0] lu_op(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [1:0]        op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Rotating priority: first valid at or above ptr, otherwise wrap to the lowest valid index.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[k] && (IDW'(k) >= ptr)) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[k]) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++)
      req_ready[k] = (state == IDLE) && found && (winner == IDW'(k));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == RESP && resp_ready)
        ptr <= (resp_id == IDW'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
    end
  end

  // Stage p0: operands of the granted requester captured at the request handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
      id_p0 <= '0;
    end else if (state == IDLE && found) begin
      id_p0 <= winner;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (winner == IDW'(k)) begin
          a_p0  <= req_a[32*k +: 32];
          b_p0  <= req_b[32*k +: 32];
          op_p0 <= req_op[2*k +: 2];
        end
      end
    end
  end

  // Stage p1: result registered in EXEC; holds through backpressure and after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data <= '0;
      resp_id   <= '0;
    end else if (state == EXEC) begin
      resp_data <= lu_op(a_p0, b_p0, op_p0);
      resp_id   <= id_p0;
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

`ifdef LU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      op_count <= '0;
    else if (state == RESP && resp_ready)
      op_count <= op_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized and directed bench for logic_unit_arbiter against a transaction-level reference model.
// Define LU_ARB_STATS_EN to also check the op_count output.
module tb_logic_unit_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a = '0;
  logic [32*N-1:0]   req_b = '0;
  logic [2*N-1:0]    req_op = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_data;
  logic [IDW-1:0]    resp_id;
  logic              busy;
`ifdef LU_ARB_STATS_EN
  logic [31:0]       op_count;
`endif

  logic_unit_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
`ifdef LU_ARB_STATS_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, results due two cycles after acceptance.
  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  bit          m_known = 1'b0;
  bit          m_pend = 1'b0;
  int          m_ptr = 0;
  int          m_acc = 0;
  int          m_id = 0;
  int          m_last_id = 0;
  int          cyc = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_last_data = '0;
  logic [31:0] m_count = '0;
  int          m_win;

  assign m_win = pick(req_valid, m_ptr);

  function automatic logic [31:0] win_data(input int w);
    for (int k = 0; k < N; k++)
      if (k == w) return ref_op(req_a[32*k +: 32], req_b[32*k +: 32], req_op[2*k +: 2]);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_known     <= 1'b1;
      m_pend      <= 1'b0;
      m_ptr       <= 0;
      m_last_data <= '0;
      m_last_id   <= 0;
      m_count     <= '0;
    end else if (m_known) begin
      if (!m_pend) begin
        if (m_win >= 0) begin
          m_pend <= 1'b1;
          m_acc  <= cyc;
          m_id   <= m_win;
          m_data <= win_data(m_win);
        end
      end else if (cyc >= m_acc + 2 && resp_ready) begin
        m_pend      <= 1'b0;
        m_ptr       <= (m_id + 1) % N;
        m_last_data <= m_data;
        m_last_id   <= m_id;
        m_count     <= m_count + 32'd1;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model_req_ready", 32'(req_ready),
          (!m_pend && m_win >= 0) ? (32'd1 << m_win) : 32'd0);
      chk("model_resp_valid", 32'(resp_valid), 32'(m_pend && cyc >= m_acc + 2));
      chk("model_busy", 32'(busy), 32'(m_pend));
      chk("model_resp_data", resp_data, (m_pend && cyc >= m_acc + 2) ? m_data : m_last_data);
      chk("model_resp_id", 32'(resp_id),
          32'((m_pend && cyc >= m_acc + 2) ? m_id : m_last_id));
`ifdef LU_ARB_STATS_EN
      chk("model_op_count", op_count, m_count);
`endif
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int t;
    req_valid = '0;
    resp_ready = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_grant(input string name, output int t);
    for (t = 0; t < 12; t++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    chk(name, 32'(t < 12), 32'd1);
  endtask

  // Single isolated request; caller guarantees the arbiter is idle.
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [31:0] exp);
    @(posedge clk); #1;
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_op[2*k +: 2]  = op;
    req_valid = '0;
    req_valid[k] = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("op_grant", 32'(req_ready), 32'd1 << k);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("op_exec_no_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("op_resp_valid", 32'(resp_valid), 32'd1);
    chk("op_resp_data", resp_data, exp);
    chk("op_resp_id", 32'(resp_id), 32'(k));
  endtask

  initial begin
    int t;
    int last_cyc;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    do_op(0, 32'hFFFFFFFC, 32'h00000004, 2'b10, 32'hFFFFFFF8);
    do_op(1, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 32'hF000F000);
    do_op(2, 32'hF0F0F0F0, 32'hFF00FF00, 2'b01, 32'hFFF0FFF0);
    do_op(3, 32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 32'h0FF00FF0);
    do_op(0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b11, 32'h000F000F);

    // All requesters valid: rotating grants, one every three cycles.
    pulse_reset();
    for (int k = 0; k < N; k++) begin
      req_a[32*k +: 32] = $urandom;
      req_b[32*k +: 32] = $urandom;
    end
    req_valid = '1;
    resp_ready = 1'b1;
    last_cyc = 0;
    for (int g = 0; g < 6; g++) begin
      wait_grant("rr_grant_wait", t);
      chk("rr_grant_order", 32'(req_ready), 32'd1 << (g % N));
      if (g > 0) chk("rr_grant_spacing", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
    end
    drain();

    // Backpressure: result held for five cycles, no grants meanwhile.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_a[64 +: 32] = 32'h12345678;
    req_b[64 +: 32] = 32'h0F0F0F0F;
    req_op[4 +: 2]  = 2'b01;
    req_valid = 4'b0100;
    wait_grant("bp_grant_wait", t);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    for (t = 0; t < 10; t++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    chk("bp_resp_wait", 32'(t < 10), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_data", resp_data, 32'h1F3F5F7F);
      chk("bp_hold_id", 32'(resp_id), 32'd2);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    chk("bp_next_grant_ptr3", 32'(req_ready), 32'b1000);
    drain();

    // Reset while in EXEC discards the op and returns ptr to 0.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_grant("rst_grant_wait", t);
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("rst_exec_no_valid", 32'(resp_valid), 32'd0);
    chk("rst_exec_data", resp_data, 32'd0);
    chk("rst_exec_busy", 32'(busy), 32'd0);
    chk("rst_exec_grant0", 32'(req_ready), 32'b0001);
    drain();

`ifdef LU_ARB_STATS_EN
    pulse_reset();
    for (int i = 0; i < 10; i++)
      do_op(i % N, 32'h0000FFFF, 32'h00FF00FF, 2'b00, 32'h000000FF);
    @(negedge clk);
    chk("stats_count_10", op_count, 32'd10);
    pulse_reset();
    @(negedge clk);
    chk("stats_reset", op_count, 32'd0);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      reset      = ($urandom_range(0, 99) == 0);
      req_valid  = N'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        req_a[32*k +: 32] = $urandom;
        req_b[32*k +: 32] = $urandom;
        req_op[2*k +: 2]  = 2'($urandom);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
